// File: rtl/player_ctrl.sv
// Player sprite controller: keyboard walk, gravity jump and walk-cycle animation, stepped once per frame tick.
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_ctrl #(
  parameter int         X_INIT      = 280,
  parameter int         Y_GROUND    = 330,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 1,
  parameter int         WIDTH       = 60,
  parameter int         HEIGHT      = 70,
  parameter int         STEP        = 5,
  parameter int         JUMP_V      = 12,
  parameter int         GRAVITY     = 1,
  parameter int         WALK_FRAMES = 8,
  parameter int         FRAME_DIV   = 3,
  parameter logic [7:0] KEY_LEFT    = 8'h1C,
  parameter logic [7:0] KEY_RIGHT   = 8'h23,
  parameter logic [7:0] KEY_JUMP    = 8'h1D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       press,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       direction,
  output logic [3:0] action,
  output logic       is_player
);

  typedef enum logic [1:0] {IDLE, WALK, AIR} state_t;

  localparam logic signed [10:0] X_LO   = 11'(X_MIN);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - WIDTH);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_GND  = 11'(Y_GROUND);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] JUMP_S = 11'(JUMP_V);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);

  state_t             state_q, state_d;
  logic [2:0]         sync_q;
  logic               tick;
  logic signed [10:0] vy_q, vy_d, vy_eff, vx;
  logic signed [10:0] x_sum, y_sum;
  logic [9:0]         px_d, py_d;
  logic               dir_d;
  logic [3:0]         frame_q, frame_d, action_d;
  logic [7:0]         div_q, div_d;
  logic               jheld_q, jheld_d;
  logic               key_l, key_r, key_j, j_new, launch, airborne, reversal;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic               credit_q, credit_d;
`endif

  // frame_clk is asynchronous: two flops to synchronise, a third for edge detect
  always_ff @(posedge Clk) begin
    if (Reset) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], frame_clk};
  end
  assign tick = sync_q[1] & ~sync_q[2];

  assign key_l    = press && (keycode == KEY_LEFT);
  assign key_r    = press && (keycode == KEY_RIGHT);
  assign key_j    = press && (keycode == KEY_JUMP);
  assign j_new    = key_j && !jheld_q;
  assign reversal = (key_l && direction) || (key_r && !direction);
  assign vx       = key_l ? -STEP_S : (key_r ? STEP_S : 11'sd0);

  always_comb begin
    state_d  = state_q;
    px_d     = px;
    py_d     = py;
    vy_d     = vy_q;
    dir_d    = direction;
    frame_d  = frame_q;
    div_d    = div_q;
    jheld_d  = jheld_q;
    launch   = 1'b0;
    airborne = 1'b0;
    vy_eff   = vy_q;
    x_sum    = $signed({1'b0, px}) + vx;
    y_sum    = 11'sd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    credit_d = credit_q;
`endif
    if (tick) begin
      jheld_d = key_j;
      if (key_l)      dir_d = 1'b0;
      else if (key_r) dir_d = 1'b1;

      if (x_sum < X_LO)      px_d = X_LO[9:0];
      else if (x_sum > X_HI) px_d = X_HI[9:0];
      else                   px_d = x_sum[9:0];

      if (state_q != AIR) launch = j_new;
`ifdef PLAYER_DOUBLE_JUMP_EN
      else if (j_new && credit_q) begin
        launch   = 1'b1;
        credit_d = 1'b0;
      end
`endif
      // A launch moves the sprite on the same tick, so the first airborne Y is ground-JUMP_V
      airborne = launch || (state_q == AIR);
      vy_eff   = launch ? -JUMP_S : vy_q;
      y_sum    = $signed({1'b0, py}) + vy_eff;

      if (airborne) begin
        if (y_sum >= Y_GND) begin
          py_d = Y_GND[9:0];
          vy_d = 11'sd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
          credit_d = 1'b1;
`endif
          frame_d = 4'd0;
          div_d   = 8'd0;
          state_d = (key_l || key_r) ? WALK : IDLE;
        end else if (y_sum <= Y_LO) begin
          py_d    = Y_LO[9:0];
          vy_d    = 11'sd0;
          state_d = AIR;
        end else begin
          py_d    = y_sum[9:0];
          vy_d    = vy_eff + GRAV_S;
          state_d = AIR;
        end
      end else if (key_l || key_r) begin
        state_d = WALK;
        if (state_q == IDLE || reversal) begin
          frame_d = 4'd0;
          div_d   = 8'd0;
        end else if (div_q == 8'(FRAME_DIV - 1)) begin
          div_d   = 8'd0;
          frame_d = (frame_q == 4'(WALK_FRAMES - 1)) ? 4'd0 : frame_q + 4'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end else begin
        state_d = IDLE;
        frame_d = 4'd0;
        div_d   = 8'd0;
      end
    end

    case (state_d)
      WALK:    action_d = frame_d;
      AIR:     action_d = 4'hE;
      default: action_d = 4'hF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      px        <= 10'(X_INIT);
      py        <= 10'(Y_GROUND);
      vy_q      <= 11'sd0;
      direction <= 1'b1;
      action    <= 4'hF;
      frame_q   <= 4'd0;
      div_q     <= 8'd0;
      jheld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      px        <= px_d;
      py        <= py_d;
      vy_q      <= vy_d;
      direction <= dir_d;
      action    <= action_d;
      frame_q   <= frame_d;
      div_q     <= div_d;
      jheld_q   <= jheld_d;
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_ff @(posedge Clk) begin
    if (Reset) credit_q <= 1'b1;
    else       credit_q <= credit_d;
  end
`endif

  assign is_player = ({1'b0, DrawX} >= {1'b0, px}) && ({1'b0, DrawX} < {1'b0, px} + 11'(WIDTH)) &&
                     ({1'b0, DrawY} >= {1'b0, py}) && ({1'b0, DrawY} < {1'b0, py} + 11'(HEIGHT));

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random key traffic against a behavioural model.
module tb_player_ctrl;

  localparam logic [7:0] K_L = 8'h1C, K_R = 8'h23, K_J = 8'h1D, K_X = 8'h55;
  localparam int ST_IDLE = 0, ST_WALK = 1, ST_AIR = 2;

  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, press = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
  logic [9:0] px, py;
  logic       direction, is_player;
  logic [3:0] action;

  int errors = 0, checks = 0;
  int m_px, m_py, m_vy, m_dir, m_st, m_walk_ticks, m_jheld, m_credit;
  int act_log[6];

  player_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .press(press), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY), .px(px), .py(py), .direction(direction),
    .action(action), .is_player(is_player)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_px = 280; m_py = 330; m_vy = 0; m_dir = 1; m_st = ST_IDLE;
    m_walk_ticks = 0; m_jheld = 0; m_credit = 1;
  endtask

  // Animation frame is simply how many ticks have been spent walking in one direction, divided by 3, mod 8
  function automatic int model_action();
    if (m_st == ST_IDLE) return 15;
    if (m_st == ST_AIR)  return 14;
    return (m_walk_ticks / 3) % 8;
  endfunction

  task automatic model_tick();
    bit l, r, j, jn, launch, rev;
    int ny;
    l  = press && keycode == K_L;
    r  = press && keycode == K_R;
    j  = press && keycode == K_J;
    jn = j && !m_jheld;
    m_jheld = j;
    rev = (l && m_dir == 1) || (r && m_dir == 0);
    if (l) m_dir = 0; else if (r) m_dir = 1;
    m_px = m_px + (l ? -5 : (r ? 5 : 0));
    if (m_px < 0) m_px = 0;
    if (m_px > 579) m_px = 579;
    launch = (m_st != ST_AIR) && jn;
`ifdef PLAYER_DOUBLE_JUMP_EN
    if (m_st == ST_AIR && jn && m_credit == 1) begin
      launch = 1;
      m_credit = 0;
    end
`endif
    if (launch) m_vy = -12;
    if (launch || m_st == ST_AIR) begin
      ny = m_py + m_vy;
      if (ny >= 330) begin
        m_py = 330; m_vy = 0; m_credit = 1;
        m_st = (l || r) ? ST_WALK : ST_IDLE;
        m_walk_ticks = 0;
      end else if (ny <= 1) begin
        m_py = 1; m_vy = 0; m_st = ST_AIR;
      end else begin
        m_py = ny; m_vy = m_vy + 1; m_st = ST_AIR;
      end
    end else if (l || r) begin
      if (m_st == ST_IDLE || rev) m_walk_ticks = 0;
      else m_walk_ticks++;
      m_st = ST_WALK;
    end else begin
      m_st = ST_IDLE;
      m_walk_ticks = 0;
    end
  endtask

  task automatic check_model(input string tag);
    int dx, dy, exp_hit;
    dx = m_px - 3 + $urandom_range(0, 66);
    dy = m_py - 3 + $urandom_range(0, 76);
    if (dx < 0) dx = 0;
    if (dx > 1023) dx = 1023;
    if (dy > 1023) dy = 1023;
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    #1;
    exp_hit = (dx >= m_px && dx < m_px + 60 && dy >= m_py && dy < m_py + 70) ? 1 : 0;
    chk({tag, ".px"}, int'(px), m_px);
    chk({tag, ".py"}, int'(py), m_py);
    chk({tag, ".direction"}, int'(direction), m_dir);
    chk({tag, ".action"}, int'(action), model_action());
    chk({tag, ".is_player"}, int'(is_player), exp_hit);
  endtask

  task automatic set_keys(input logic p, input logic [7:0] k);
    press = p;
    keycode = k;
  endtask

  // One slow, asynchronous frame_clk pulse; the DUT has settled well before its low phase ends
  task automatic do_tick(input string tag);
    #3 frame_clk = 1'b1;
    repeat (5) @(posedge Clk);
    #2 frame_clk = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    model_tick();
    check_model(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) do_tick(tag);
  endtask

  task automatic probe(input int dx, input int dy, input int exp, input string name);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    #1;
    chk(name, int'(is_player), exp);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("reset.px", int'(px), 280);
    chk("reset.py", int'(py), 330);
    chk("reset.action", int'(action), 15);
    chk("reset.direction", int'(direction), 1);
    check_model("reset");

    ticks(20, "idle");
    chk("idle20.px", int'(px), 280);
    chk("idle20.action", int'(action), 15);

    set_keys(1'b1, K_R);
    for (int i = 0; i < 6; i++) begin
      do_tick("walk_r");
      act_log[i] = int'(action);
    end
    chk("walk6.px", int'(px), 310);
    chk("walk6.act0", act_log[0], 0);
    chk("walk6.act2", act_log[2], 0);
    chk("walk6.act3", act_log[3], 1);
    chk("walk6.act5", act_log[5], 1);
    ticks(18, "walk_r");
    chk("walk24.action", int'(action), 7);
    do_tick("walk_r");
    chk("walk25.action_wrap", int'(action), 0);

    set_keys(1'b0, K_X);
    do_tick("stop");
    chk("stop.action", int'(action), 15);

    set_keys(1'b1, K_L);
    ticks(90, "walk_l");
    chk("left_clamp.px", int'(px), 0);
    chk("left_clamp.direction", int'(direction), 0);

    set_keys(1'b1, K_R);
    do_tick("rev");
    chk("reverse.action", int'(action), 0);
    ticks(120, "walk_r2");
    chk("right_clamp.px", int'(px), 579);

    set_keys(1'b0, K_X);
    do_tick("stop2");

    set_keys(1'b1, K_J);
    for (int i = 1; i <= 27; i++) begin
      do_tick("jump");
      if (i == 1)  chk("jump.t1.py", int'(py), 318);
      if (i == 2)  chk("jump.t2.py", int'(py), 307);
      if (i == 3)  chk("jump.t3.py", int'(py), 297);
      if (i == 24) chk("jump.t24.action", int'(action), 14);
      if (i == 25) chk("jump.land.py", int'(py), 330);
      if (i == 25) chk("jump.land.action", int'(action), 15);
      if (i == 27) chk("jump.held_no_retrigger", int'(py), 330);
    end

    probe(579 + 59, 330, 1, "probe.x59");
    probe(579 + 60, 330, 0, "probe.x60");
    probe(579, 330 + 69, 1, "probe.y69");
    probe(579, 330 + 70, 0, "probe.y70");

    set_keys(1'b0, K_X);
    do_tick("pre_rst");
    set_keys(1'b1, K_J);
    do_tick("rst_jump");
    set_keys(1'b0, K_X);
    ticks(3, "rst_air");
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    chk("midair_reset.py", int'(py), 330);
    chk("midair_reset.action", int'(action), 15);
    check_model("midair_reset");

    set_keys(1'b1, K_J);
    do_tick("dj1");
    set_keys(1'b0, K_X);
    do_tick("dj2");
    set_keys(1'b1, K_J);
    do_tick("dj3");
`ifdef PLAYER_DOUBLE_JUMP_EN
    chk("double_jump.py", int'(py), 295);
`else
    chk("double_jump_ignored.py", int'(py), 297);
`endif
    set_keys(1'b0, K_X);
    ticks(40, "dj_fall");

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: set_keys(1'b0, K_X);
        1: set_keys(1'b1, K_L);
        2: set_keys(1'b1, K_R);
        3: set_keys(1'b1, K_J);
        default: set_keys(1'b1, K_X);
      endcase
      do_tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
